// File: rtl/seg7_scan_driver_if.sv
// Bundle of the scan driver's control, data and display signals.
// master: stimulus/datapath side; slave: the scan driver itself.
interface seg7_scan_driver_if;
  logic        TICK_1MS;
  logic        BLINK;
  logic        BLINK_EN;
  logic        LOAD;
  logic [15:0] DATA;
  logic [3:0]  DP;
  logic [3:0]  AN;
  logic [7:0]  SEG;
  logic [1:0]  DIGIT_IDX;

  modport master (
    output TICK_1MS, BLINK, BLINK_EN, LOAD, DATA, DP,
    input  AN, SEG, DIGIT_IDX
  );

  modport slave (
    input  TICK_1MS, BLINK, BLINK_EN, LOAD, DATA, DP,
    output AN, SEG, DIGIT_IDX
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed 7-segment scan driver with blink and optional leading-zero blanking.
// Optional feature macro: LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
  parameter int SYNC_STAGES = 2,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input logic              CLK,
  input logic              RST_N,
  seg7_scan_driver_if.slave bus
);

  localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'b1111 : 4'b0000;
  localparam logic [7:0] SEG_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;

  // Hex font, gfedcba with 1 = segment lit.
  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] f;
    case (v)
      4'h0:    f = 7'b0111111;
      4'h1:    f = 7'b0000110;
      4'h2:    f = 7'b1011011;
      4'h3:    f = 7'b1001111;
      4'h4:    f = 7'b1100110;
      4'h5:    f = 7'b1101101;
      4'h6:    f = 7'b1111101;
      4'h7:    f = 7'b0000111;
      4'h8:    f = 7'b1111111;
      4'h9:    f = 7'b1101111;
      4'hA:    f = 7'b1110111;
      4'hB:    f = 7'b1111100;
      4'hC:    f = 7'b0111001;
      4'hD:    f = 7'b1011110;
      4'hE:    f = 7'b1111001;
      4'hF:    f = 7'b1110001;
      default: f = 7'b0000000;
    endcase
    return f;
  endfunction

  logic [SYNC_STAGES-1:0] tick_sync_r;
  logic                   tick_hist_r;
  logic [SYNC_STAGES-1:0] blink_sync_r;
  logic                   tick_p_s;
  logic                   blank_s;
  logic                   lz_dark_s;
  logic [1:0]             idx_r;
  logic [15:0]            disp_r;
  logic [3:0]             dp_r;
  logic [3:0]             an_r;
  logic [7:0]             seg_r;
  logic [3:0]             an_nxt_s;
  logic [7:0]             seg_nxt_s;
  logic [3:0]             nibble_s;

  // Synchronizers for the divider-domain levels plus tick edge history.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_sync_r  <= '0;
      tick_hist_r  <= 1'b0;
      blink_sync_r <= '0;
    end else begin
      tick_sync_r  <= {tick_sync_r[SYNC_STAGES-2:0], bus.TICK_1MS};
      tick_hist_r  <= tick_sync_r[SYNC_STAGES-1];
      blink_sync_r <= {blink_sync_r[SYNC_STAGES-2:0], bus.BLINK};
    end
  end

  assign tick_p_s = tick_sync_r[SYNC_STAGES-1] & ~tick_hist_r;
  assign blank_s  = bus.BLINK_EN & ~blink_sync_r[SYNC_STAGES-1];

  // Scan index and captured display value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx_r  <= 2'd0;
      disp_r <= 16'h0000;
      dp_r   <= 4'h0;
    end else begin
      if (tick_p_s) begin
        idx_r <= idx_r + 2'd1;
      end
      if (bus.LOAD) begin
        disp_r <= bus.DATA;
        dp_r   <= bus.DP;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is dark when it and every digit to its left are zero, unless its dp is lit.
  always_comb begin
    lz_dark_s = 1'b0;
    case (idx_r)
      2'd3:    lz_dark_s = (disp_r[15:12] == 4'h0) & ~dp_r[3];
      2'd2:    lz_dark_s = (disp_r[15:8] == 8'h00) & ~dp_r[2];
      2'd1:    lz_dark_s = (disp_r[15:4] == 12'h000) & ~dp_r[1];
      default: lz_dark_s = 1'b0;
    endcase
  end
`else
  assign lz_dark_s = 1'b0;
`endif

  assign nibble_s = disp_r[{idx_r, 2'b00} +: 4];

  // Next anode/cathode pattern for the selected digit, polarity applied last.
  always_comb begin
    an_nxt_s  = AN_OFF;
    seg_nxt_s = SEG_OFF;
    if (blank_s || lz_dark_s) begin
      an_nxt_s  = AN_OFF;
      seg_nxt_s = SEG_OFF;
    end else begin
      an_nxt_s  = (4'b0001 << idx_r) ^ {4{ACTIVE_LOW}};
      seg_nxt_s = {dp_r[idx_r], hex_font(nibble_s)} ^ {8{ACTIVE_LOW}};
    end
  end

  // Registered display outputs keep AN/SEG glitch-free.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      an_r  <= AN_OFF;
      seg_r <= SEG_OFF;
    end else begin
      an_r  <= an_nxt_s;
      seg_r <= seg_nxt_s;
    end
  end

  assign bus.AN        = an_r;
  assign bus.SEG       = seg_r;
  assign bus.DIGIT_IDX = idx_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed scoreboard bench for seg7_scan_driver (default parameters, active-low board).
module tb_seg7_scan_driver;

  logic CLK;
  logic RST_N;
  seg7_scan_driver_if bus ();

  seg7_scan_driver #(.SYNC_STAGES(2), .ACTIVE_LOW(1'b1)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Active-low cathode patterns {dp,g..a} for hex 0..F, dp off.
  localparam logic [7:0] FONT_AL [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  typedef struct {
    string       tag;
    logic [13:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [1:0]  m_idx  = 2'd0;
  logic [15:0] m_data = 16'h0000;
  logic [3:0]  m_dp   = 4'h0;
  logic        m_blank = 1'b0;

  function automatic logic [11:0] model(input logic [1:0] i, input logic [15:0] d,
                                        input logic [3:0] p, input logic b);
    logic [3:0] an;
    logic [7:0] seg;
    logic       dark;
    dark = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    if (i != 2'd0 && ((d >> (4 * i)) == 16'h0000) && !p[i]) dark = 1'b1;
`endif
    if (b || dark) return {4'hF, 8'hFF};
    seg = FONT_AL[d[i*4 +: 4]];
    if (p[i]) seg[7] = 1'b0;
    an    = 4'hF;
    an[i] = 1'b0;
    return {an, seg};
  endfunction

  task automatic expect_raw(input string tag, input logic [3:0] an, input logic [7:0] seg,
                            input logic [1:0] idx);
    exp_t e;
    e.tag = tag;
    e.val = {an, seg, idx};
    sb.push_back(e);
  endtask

  task automatic expect_cur(input string tag);
    logic [11:0] m;
    m = model(m_idx, m_data, m_dp, m_blank);
    expect_raw(tag, m[11:8], m[7:0], m_idx);
  endtask

  task automatic check();
    exp_t        e;
    logic [13:0] obs;
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d entries expected >0", sb.size());
    end else begin
      e   = sb.pop_front();
      obs = {bus.AN, bus.SEG, bus.DIGIT_IDX};
      assert (obs === e.val)
      else begin
        n_fail++;
        $error("FAIL %s: observed AN=%b SEG=%h IDX=%0d expected AN=%b SEG=%h IDX=%0d",
               e.tag, obs[13:10], obs[9:2], obs[1:0], e.val[13:10], e.val[9:2], e.val[1:0]);
      end
    end
  endtask

  task automatic chk(input string tag);
    expect_cur(tag);
    check();
  endtask

  task automatic do_tick();
    bus.TICK_1MS = 1'b1;
    repeat (4) @(negedge CLK);
    bus.TICK_1MS = 1'b0;
    repeat (4) @(negedge CLK);
    m_idx = m_idx + 2'd1;
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    bus.LOAD = 1'b1;
    bus.DATA = d;
    bus.DP   = p;
    @(negedge CLK);
    bus.LOAD = 1'b0;
    @(negedge CLK);
    m_data = d;
    m_dp   = p;
  endtask

  initial begin
    logic [11:0] m_old;
    RST_N        = 1'b0;
    bus.TICK_1MS = 1'b0;
    bus.BLINK    = 1'b1;
    bus.BLINK_EN = 1'b0;
    bus.LOAD     = 1'b0;
    bus.DATA     = 16'h0000;
    bus.DP       = 4'h0;
    repeat (3) @(negedge CLK);
    expect_raw("reset_state", 4'hF, 8'hFF, 2'd0);
    check();

    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    chk("after_reset_zero");

    // Scan through 16'h1A3F.
    do_load(16'h1A3F, 4'h0);
    chk("load_digit0_F");
    for (int k = 0; k < 4; k++) begin
      do_tick();
      chk($sformatf("scan_tick_%0d", k + 1));
    end

    // Tick latency and single advance on a held level.
    m_old = model(m_idx, m_data, m_dp, 1'b0);
    bus.TICK_1MS = 1'b1;
    @(negedge CLK);
    expect_raw("latency_k0", m_old[11:8], m_old[7:0], m_idx);
    check();
    @(negedge CLK);
    expect_raw("latency_k1", m_old[11:8], m_old[7:0], m_idx);
    check();
    @(negedge CLK);
    expect_raw("latency_idx_k2", m_old[11:8], m_old[7:0], m_idx + 2'd1);
    check();
    m_idx = m_idx + 2'd1;
    @(negedge CLK);
    chk("latency_an_k3");
    repeat (100) @(negedge CLK);
    chk("held_high_one_advance");
    bus.TICK_1MS = 1'b0;
    repeat (4) @(negedge CLK);

    // LOAD coincident with tick_p.
    do_load(16'h0000, 4'h0);
    chk("zero_digit");
    bus.TICK_1MS = 1'b1;
    repeat (2) @(negedge CLK);
    bus.LOAD = 1'b1;
    bus.DATA = 16'h8888;
    @(negedge CLK);
    bus.LOAD = 1'b0;
    m_idx  = m_idx + 2'd1;
    m_data = 16'h8888;
    @(negedge CLK);
    chk("load_with_tick_8");
    bus.TICK_1MS = 1'b0;
    repeat (4) @(negedge CLK);

    // LOAD held over several cycles: last value wins.
    bus.LOAD = 1'b1;
    bus.DATA = 16'h1111;
    @(negedge CLK);
    bus.DATA = 16'h2222;
    @(negedge CLK);
    bus.DATA = 16'h3456;
    @(negedge CLK);
    bus.LOAD = 1'b0;
    @(negedge CLK);
    m_data = 16'h3456;
    chk("load_held_last_wins");

    // Blink.
    bus.BLINK_EN = 1'b1;
    repeat (3) @(negedge CLK);
    chk("blink_en_blink_high");
    bus.BLINK = 1'b0;
    repeat (3) @(negedge CLK);
    m_blank = 1'b1;
    chk("blink_low_blank");
    do_tick();
    chk("blank_idx_scans");
    bus.BLINK = 1'b1;
    repeat (3) @(negedge CLK);
    m_blank = 1'b0;
    chk("blink_resume");
    bus.BLINK = 1'b0;
    repeat (3) @(negedge CLK);
    m_blank = 1'b1;
    chk("blink_low_again");
    bus.BLINK_EN = 1'b0;
    @(negedge CLK);
    m_blank = 1'b0;
    chk("blink_en_off_next_clk");
    bus.BLINK = 1'b1;

    // Leading zeros and decimal point override.
    do_load(16'h0042, 4'h0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lz_0042_idx%0d", m_idx));
      do_tick();
    end
    do_load(16'h0042, 4'b0100);
    while (m_idx != 2'd2) do_tick();
    chk("lz_dp_digit2");
    do_load(16'h0000, 4'h0);
    while (m_idx != 2'd0) do_tick();
    chk("lz_zero_digit0");
    do_tick();
    chk("lz_zero_digit1");

    // Asynchronous reset between clock edges.
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    expect_raw("async_reset_mid_scan", 4'hF, 8'hFF, 2'd0);
    check();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
